// File: rtl/lock_status_display.sv
// Lock state bus consumer: debounce, 7-seg glyph, indicators, buzzer.
// Optional lamp test input enabled by defining LOCK_DISP_LAMPTEST_EN.
module lock_status_display #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 4,
  parameter int STABLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state_in,
  input  logic       state_valid,
`ifdef LOCK_DISP_LAMPTEST_EN
  input  logic       lamp_test,
`endif
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       led_open,
  output logic       led_alarm,
  output logic       buzzer,
  output logic       state_err
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int CW = $clog2(STABLE_CYC + 1);

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_SET   = 3'd1;
  localparam logic [2:0] C_OPEN  = 3'd2;
  localparam logic [2:0] C_ALARM = 3'd3;
  localparam logic [2:0] C_PWD   = 3'd4;

  typedef enum logic [1:0] {
    D_SHOW   = 2'd0,
    D_CHANGE = 2'd1,
    D_ERR    = 2'd2
  } disp_e;

  logic [PW-1:0] pre_q;
  logic          tick;
  logic          blink_q;
  logic          buzz_q;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick) blink_q <= ~blink_q;
    end
  end

  logic [2:0]    samp_q;
  logic          samp_v_q;
  logic [2:0]    prev_q;
  logic [2:0]    acc_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nx;
  logic          accept;
  logic          code_ok;

  // Saturate at STABLE_CYC so a long-held code stays qualified.
  always_comb begin
    cnt_nx = CW'(1);
    if (samp_q == prev_q) begin
      if (cnt_q == CW'(STABLE_CYC)) cnt_nx = cnt_q;
      else cnt_nx = cnt_q + CW'(1);
    end
  end

  assign accept  = samp_v_q && (cnt_nx == CW'(STABLE_CYC))
                   && (samp_q != acc_q);
  assign code_ok = (samp_q <= C_PWD);

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q   <= C_IDLE;
      samp_v_q <= 1'b0;
      prev_q   <= C_IDLE;
      cnt_q    <= '0;
      acc_q    <= C_IDLE;
      buzz_q   <= 1'b0;
    end else begin
      samp_q   <= state_in;
      samp_v_q <= state_valid;
      if (samp_v_q) begin
        prev_q <= samp_q;
        cnt_q  <= cnt_nx;
      end
      if (accept) acc_q <= samp_q;
      if (acc_q != C_ALARM) buzz_q <= 1'b0;
      else if (tick) buzz_q <= ~buzz_q;
    end
  end

  disp_e         d_q, d_nx;
  logic [HW-1:0] hold_q, hold_nx;
  logic          err_q, err_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= D_SHOW;
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      d_q    <= d_nx;
      hold_q <= hold_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    d_nx    = d_q;
    hold_nx = hold_q;
    err_nx  = err_q;
    unique case (1'b1)
      accept && !code_ok: begin
        d_nx   = D_ERR;
        err_nx = 1'b1;
      end
      accept && code_ok: begin
        d_nx    = D_CHANGE;
        hold_nx = HW'(HOLD_TICKS);
        err_nx  = 1'b0;
      end
      !accept && (d_q == D_CHANGE) && tick: begin
        hold_nx = hold_q - HW'(1);
        if (hold_q == HW'(1)) d_nx = D_SHOW;
      end
      default: ;
    endcase
  end

  logic [6:0] seg_d;
  logic       dp_d, open_d, alarm_d, buzz_d;

  always_comb begin
    seg_d   = 7'h00;
    dp_d    = 1'b0;
    open_d  = (acc_q == C_OPEN);
    alarm_d = (acc_q == C_ALARM) && blink_q;
    buzz_d  = buzz_q;
    unique case (d_q)
      D_CHANGE: begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end
      D_ERR: seg_d = 7'h79;
      default: begin
        unique case (acc_q)
          C_IDLE: seg_d = 7'h40;
          C_SET: begin
            seg_d = 7'h6D;
            dp_d  = 1'b1;
          end
          C_OPEN:  seg_d = 7'h3F;
          C_ALARM: seg_d = blink_q ? 7'h77 : 7'h00;
          C_PWD: begin
            seg_d = 7'h73;
            dp_d  = blink_q;
          end
          default: seg_d = 7'h00;
        endcase
      end
    endcase
`ifdef LOCK_DISP_LAMPTEST_EN
    if (lamp_test) begin
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      open_d  = 1'b1;
      alarm_d = 1'b1;
      buzz_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out   <= 7'h00;
      dp_out    <= 1'b0;
      led_open  <= 1'b0;
      led_alarm <= 1'b0;
      buzzer    <= 1'b0;
      state_err <= 1'b0;
    end else begin
      seg_out   <= seg_d;
      dp_out    <= dp_d;
      led_open  <= open_d;
      led_alarm <= alarm_d;
      buzzer    <= buzz_d;
      state_err <= err_q;
    end
  end

endmodule

// File: tb/tb_lock_status_display.sv
// Directed bench for lock_status_display (TICK_DIV=4, HOLD=2, STABLE=2).
// Lamp test section is built only with LOCK_DISP_LAMPTEST_EN.
module tb_lock_status_display;

  localparam int TD = 4;
  localparam int HT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_in = 3'd0;
  logic       state_valid = 1'b0;
`ifdef LOCK_DISP_LAMPTEST_EN
  logic       lamp_test = 1'b0;
`endif
  logic [6:0] seg_out;
  logic       dp_out, led_open, led_alarm, buzzer, state_err;

  int ecnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  lock_status_display #(
    .TICK_DIV(TD), .HOLD_TICKS(HT), .STABLE_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .state_in(state_in),
    .state_valid(state_valid),
`ifdef LOCK_DISP_LAMPTEST_EN
    .lamp_test(lamp_test),
`endif
    .seg_out(seg_out),
    .dp_out(dp_out),
    .led_open(led_open),
    .led_alarm(led_alarm),
    .buzzer(buzzer),
    .state_err(state_err)
  );

  always #5 clk = ~clk;

  // Edge index since reset release; prescaler ticks on multiples of TD.
  always @(posedge clk) begin
    if (rst) ecnt = 0;
    else ecnt = ecnt + 1;
  end

  typedef struct {
    logic [2:0] code;
    logic [6:0] s0, s1;
    logic       d0, d1, lo, la0, la1, alarm;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, ecnt, act, exp);
    end
  endtask

  function automatic logic blink_at(input int k);
    return (((k - 1) / TD) % 2) == 1;
  endfunction

  function automatic logic buzz_at(input int k, input int a);
    return ((((k - 1) / TD) - (a / TD)) % 2) == 1;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_seg"}, 32'(seg_out), 32'h00);
    chk({nm, "_dp"}, 32'(dp_out), 0);
    chk({nm, "_open"}, 32'(led_open), 0);
    chk({nm, "_alarm"}, 32'(led_alarm), 0);
    chk({nm, "_buz"}, 32'(buzzer), 0);
    chk({nm, "_err"}, 32'(state_err), 0);
  endtask

  task automatic hold_code(input logic [2:0] c, input int n,
                           output int a);
    a = ecnt + n + 1;
    state_in = c;
    state_valid = 1'b1;
    repeat (n) @(negedge clk);
    state_valid = 1'b0;
  endtask

  task automatic wait_edge(input int a);
    for (int g = 0; g < 64 && ecnt < a; g++) @(negedge clk);
    chk("sync", 32'(ecnt), 32'(a));
  endtask

  task automatic flash(input int a, input logic [6:0] prev);
    int t2;
    t2 = (a / TD + 1) * TD + TD * (HT - 1);
    wait_edge(a);
    chk("pre_flash_seg", 32'(seg_out), 32'(prev));
    for (int k = a + 1; k <= t2; k++) begin
      @(negedge clk);
      chk("flash_seg", 32'(seg_out), 32'h7F);
      chk("flash_dp", 32'(dp_out), 1);
      chk("flash_err", 32'(state_err), 0);
    end
    @(negedge clk);
  endtask

  task automatic show_run(input int n, input vec_t v, input int a);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = blink_at(ecnt);
      chk("show_seg", 32'(seg_out), 32'(b ? v.s1 : v.s0));
      chk("show_dp", 32'(dp_out), 32'(b ? v.d1 : v.d0));
      chk("show_open", 32'(led_open), 32'(v.lo));
      chk("show_alarm", 32'(led_alarm), 32'(b ? v.la1 : v.la0));
      chk("show_buz", 32'(buzzer), 32'(v.alarm ? buzz_at(ecnt, a) : 1'b0));
      chk("show_err", 32'(state_err), 0);
      @(negedge clk);
    end
  endtask

  function automatic logic [6:0] glyph(input vec_t v, input int k);
    return blink_at(k) ? v.s1 : v.s0;
  endfunction

  initial begin
    vec_t pv, vi, vp;
    int   a, a2, e0;

    tbl[0] = '{3'd2, 7'h3F, 7'h3F, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{3'd3, 7'h00, 7'h77, 0, 0, 0, 0, 1, 1};
    tbl[2] = '{3'd4, 7'h73, 7'h73, 0, 1, 0, 0, 0, 0};
    tbl[3] = '{3'd1, 7'h6D, 7'h6D, 1, 1, 0, 0, 0, 0};
    tbl[4] = '{3'd0, 7'h40, 7'h40, 0, 0, 0, 0, 0, 0};
    vi = '{3'd0, 7'h40, 7'h40, 0, 0, 0, 0, 0, 0};
    vp = tbl[2];

    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_seg", 32'(seg_out), 32'h40);
    chk("post_rst_dp", 32'(dp_out), 0);
    chk("post_rst_open", 32'(led_open), 0);
    chk("post_rst_err", 32'(state_err), 0);

    pv = vi;
    for (int i = 0; i < 5; i++) begin
      hold_code(tbl[i].code, 2, a);
      flash(a, glyph(pv, a));
      show_run(10, tbl[i], a);
      pv = tbl[i];
    end

    // Single-cycle glitch must not be accepted.
    e0 = ecnt;
    state_in = 3'd2;
    state_valid = 1'b1;
    @(negedge clk);
    state_in = 3'd4;
    repeat (2) @(negedge clk);
    state_valid = 1'b0;
    chk("glitch_open", 32'(led_open), 0);
    flash(e0 + 4, 7'h40);
    chk("glitch_open2", 32'(led_open), 0);
    show_run(8, vp, 0);

    // Invalid code split by invalid-bus cycles still debounces.
    e0 = ecnt;
    state_in = 3'd6;
    state_valid = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
    repeat (3) @(negedge clk);
    state_valid = 1'b1;
    @(negedge clk);
    state_valid = 1'b0;
    wait_edge(e0 + 6);
    chk("pre_err_seg", 32'(seg_out), 32'h73);
    chk("pre_err_flag", 32'(state_err), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("err_seg", 32'(seg_out), 32'h79);
      chk("err_dp", 32'(dp_out), 0);
      chk("err_flag", 32'(state_err), 1);
      chk("err_open", 32'(led_open), 0);
      chk("err_buz", 32'(buzzer), 0);
    end

    hold_code(3'd0, 2, a);
    wait_edge(a);
    chk("err_hold_flag", 32'(state_err), 1);
    flash(a, 7'h79);
    show_run(4, vi, 0);

    // Second acceptance inside the flash reloads the hold counter.
    for (int g = 0; g < 8 && (ecnt % TD) != 0; g++) @(negedge clk);
    hold_code(3'd1, 2, a);
    hold_code(3'd2, 2, a2);
    chk("reload_gap", 32'(a2 - a), 2);
    flash(a2, 7'h7F);
    show_run(4, tbl[0], 0);

    // Reset in the middle of a flash.
    hold_code(3'd3, 2, a);
    wait_edge(a + 2);
    chk("mid_flash_seg", 32'(seg_out), 32'h7F);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_seg", 32'(seg_out), 32'h40);
    chk("mid_rst_dp", 32'(dp_out), 0);

`ifdef LOCK_DISP_LAMPTEST_EN
    hold_code(3'd3, 2, a);
    flash(a, 7'h40);
    show_run(5, tbl[1], a);
    lamp_test = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lamp_seg", 32'(seg_out), 32'h7F);
      chk("lamp_dp", 32'(dp_out), 1);
      chk("lamp_open", 32'(led_open), 1);
      chk("lamp_alarm", 32'(led_alarm), 1);
      chk("lamp_buz", 32'(buzzer), 0);
    end
    lamp_test = 1'b0;
    @(negedge clk);
    show_run(10, tbl[1], a);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
